// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
//   Execute-stage front end between issue logic and the combinational ALU.
//   Takes one request at a time over a valid/ready channel and registers the
//   operands. Opcodes 0..MAX_ALU_OP are run on the external ALU. MUL_OP runs
//   on an internal shift-add multiplier. Every other opcode is answered
//   with an error response. Each request returns exactly one tagged response
//   over a valid/ready channel.
//
// Ports
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_req_valid/o_req_ready request handshake
//   i_req_op/x/y/tag        request opcode, operands, destination tag
//   o_alu_op/x/y            last registered request, presented to the ALU
//   i_alu_w, i_alu_cmp      ALU result and compare flag
//   o_rsp_valid/i_rsp_ready response handshake
//   o_rsp_w/cmp/tag/err     response payload
//   o_busy                  high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module alu_issue_ctrl #(
  parameter int         WIDTH      = 32,
  parameter logic [4:0] MAX_ALU_OP = 5'd12,
  parameter logic [4:0] MUL_OP     = 5'd13
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [4:0]       i_req_op,
  input  logic [WIDTH-1:0] i_req_x,
  input  logic [WIDTH-1:0] i_req_y,
  input  logic [4:0]       i_req_tag,
  output logic [4:0]       o_alu_op,
  output logic [WIDTH-1:0] o_alu_x,
  output logic [WIDTH-1:0] o_alu_y,
  input  logic [WIDTH-1:0] i_alu_w,
  input  logic             i_alu_cmp,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [WIDTH-1:0] o_rsp_w,
  output logic             o_rsp_cmp,
  output logic [4:0]       o_rsp_tag,
  output logic             o_rsp_err,
  output logic             o_busy
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t           r_state;
  logic [4:0]       r_op;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [4:0]       r_tag;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [CNT_W-1:0] r_cnt;
  logic             r_req_ready;
  logic             r_busy;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_w;
  logic             r_rsp_cmp;
  logic [4:0]       r_rsp_tag;
  logic             r_rsp_err;

  logic             w_accept;
  logic [WIDTH-1:0] w_acc_next;

  // r_req_ready is only ever high in IDLE, so this is the request handshake.
  assign w_accept   = i_req_valid & r_req_ready;
  // One shift-add step; carries beyond WIDTH are dropped on purpose.
  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  // Control FSM, operand/multiplier datapath and all registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_op        <= 5'd0;
      r_x         <= '0;
      r_y         <= '0;
      r_tag       <= 5'd0;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_cnt       <= '0;
      r_req_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_w     <= '0;
      r_rsp_cmp   <= 1'b0;
      r_rsp_tag   <= 5'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op        <= i_req_op;
            r_x         <= i_req_x;
            r_y         <= i_req_y;
            r_tag       <= i_req_tag;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            if (i_req_op <= MAX_ALU_OP) begin
              r_state <= S_EXEC;
            end else if (i_req_op == MUL_OP) begin
              r_state  <= S_MUL;
              r_acc    <= '0;
              r_mcand  <= i_req_x;
              r_mplier <= i_req_y;
              r_cnt    <= '0;
            end else begin
              r_state   <= S_RESP;
              r_rsp_w   <= '0;
              r_rsp_cmp <= 1'b0;
              r_rsp_err <= 1'b1;
              r_rsp_tag <= i_req_tag;
            end
          end
        end

        S_EXEC: begin
          // The registered operands have been on o_alu_* for the whole cycle.
          r_rsp_w   <= i_alu_w;
          r_rsp_cmp <= i_alu_cmp;
          r_rsp_err <= 1'b0;
          r_rsp_tag <= r_tag;
          r_state   <= S_RESP;
        end

        S_MUL: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            r_rsp_w   <= w_acc_next;
            r_rsp_cmp <= 1'b0;
            r_rsp_err <= 1'b0;
            r_rsp_tag <= r_tag;
            r_state   <= S_RESP;
          end
        end

        S_RESP: begin
          // First RESP cycle raises o_rsp_valid from the already-settled payload;
          // the handshake is only honoured once valid is visible.
          if (!r_rsp_valid) begin
            r_rsp_valid <= 1'b1;
          end else if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
          r_busy      <= 1'b0;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_req_ready = r_req_ready;
  assign o_busy      = r_busy;
  assign o_alu_op    = r_op;
  assign o_alu_x     = r_x;
  assign o_alu_y     = r_y;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_w     = r_rsp_w;
  assign o_rsp_cmp   = r_rsp_cmp;
  assign o_rsp_tag   = r_rsp_tag;
  assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_ctrl
//   Directed bench for alu_issue_ctrl. A tiny ALU model answers
//   w = 32'hA5A5_0000 + (x ^ y) + op, cmp = op[0]; expected values below are
//   worked out by hand from that model and from the multiply definitions.
// -----------------------------------------------------------------------------
module tb_alu_issue_ctrl;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic             i_req_valid;
  logic             o_req_ready;
  logic [4:0]       i_req_op;
  logic [WIDTH-1:0] i_req_x;
  logic [WIDTH-1:0] i_req_y;
  logic [4:0]       i_req_tag;
  logic [4:0]       o_alu_op;
  logic [WIDTH-1:0] o_alu_x;
  logic [WIDTH-1:0] o_alu_y;
  logic [WIDTH-1:0] i_alu_w;
  logic             i_alu_cmp;
  logic             o_rsp_valid;
  logic             i_rsp_ready;
  logic [WIDTH-1:0] o_rsp_w;
  logic             o_rsp_cmp;
  logic [4:0]       o_rsp_tag;
  logic             o_rsp_err;
  logic             o_busy;

  int n_checks;
  int n_pass;

  alu_issue_ctrl #(.WIDTH(WIDTH)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_op    (i_req_op),
    .i_req_x     (i_req_x),
    .i_req_y     (i_req_y),
    .i_req_tag   (i_req_tag),
    .o_alu_op    (o_alu_op),
    .o_alu_x     (o_alu_x),
    .o_alu_y     (o_alu_y),
    .i_alu_w     (i_alu_w),
    .i_alu_cmp   (i_alu_cmp),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_w     (o_rsp_w),
    .o_rsp_cmp   (o_rsp_cmp),
    .o_rsp_tag   (o_rsp_tag),
    .o_rsp_err   (o_rsp_err),
    .o_busy      (o_busy)
  );

  // Simple combinational ALU stand-in
  assign i_alu_w   = 32'hA5A5_0000 + (o_alu_x ^ o_alu_y) + {27'd0, o_alu_op};
  assign i_alu_cmp = o_alu_op[0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and hold it until it is taken; returns edges waited.
  task automatic accept(input logic [4:0] op, input logic [WIDTH-1:0] x,
                        input logic [WIDTH-1:0] y, input logic [4:0] tag,
                        output int waited);
    i_req_op    = op;
    i_req_x     = x;
    i_req_y     = y;
    i_req_tag   = tag;
    i_req_valid = 1'b1;
    waited      = 0;
    while (!o_req_ready && waited < 100) begin
      tick();
      waited++;
    end
    check("accept_ready", {31'd0, o_req_ready}, 32'd1);
    tick();
    i_req_valid = 1'b0;
  endtask

  // Count edges after the accept edge until rsp_valid shows up.
  task automatic wait_rsp(output int edges);
    edges = 0;
    do begin
      tick();
      edges++;
    end while (!o_rsp_valid && edges < 100);
  endtask

  task automatic run_op(input string name, input logic [4:0] op,
                        input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input logic [4:0] tag, input int exp_lat,
                        input logic [WIDTH-1:0] exp_w, input logic exp_cmp,
                        input logic exp_err);
    int  waited;
    int  lat;
    logic saved_ready;
    accept(op, x, y, tag, waited);
    check({name, "_accept_wait"}, waited, 32'd0);
    wait_rsp(lat);
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_rsp_w"}, o_rsp_w, exp_w);
    check({name, "_rsp_cmp"}, {31'd0, o_rsp_cmp}, {31'd0, exp_cmp});
    check({name, "_rsp_tag"}, {27'd0, o_rsp_tag}, {27'd0, tag});
    check({name, "_rsp_err"}, {31'd0, o_rsp_err}, {31'd0, exp_err});
    saved_ready = i_rsp_ready;
    i_rsp_ready = 1'b1;
    tick();
    i_rsp_ready = saved_ready;
    check({name, "_ready_after_hs"}, {31'd0, o_req_ready}, 32'd1);
    check({name, "_valid_after_hs"}, {31'd0, o_rsp_valid}, 32'd0);
  endtask

  initial begin
    int waited;
    int lat;
    bit saw_valid;
    logic [WIDTH-1:0] held_w;

    n_checks    = 0;
    n_pass      = 0;
    rst         = 1'b1;
    i_req_valid = 1'b0;
    i_req_op    = 5'd0;
    i_req_x     = '0;
    i_req_y     = '0;
    i_req_tag   = 5'd0;
    i_rsp_ready = 1'b0;

    // Reset state
    #3;
    check("rst_req_ready", {31'd0, o_req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_alu_x", o_alu_x, 32'd0);
    check("rst_rsp_w", o_rsp_w, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // ALU forward with cycle-accurate view of EXEC
    accept(5'd1, 32'h1, 32'h1, 5'd7, waited);
    check("fwd_busy", {31'd0, o_busy}, 32'd1);
    check("fwd_req_ready", {31'd0, o_req_ready}, 32'd0);
    check("fwd_alu_op", {27'd0, o_alu_op}, 32'd1);
    check("fwd_alu_x", o_alu_x, 32'd1);
    check("fwd_alu_y", o_alu_y, 32'd1);
    wait_rsp(lat);
    check("fwd_latency", lat, 32'd2);
    check("fwd_rsp_w", o_rsp_w, 32'hA5A5_0001);
    check("fwd_rsp_cmp", {31'd0, o_rsp_cmp}, 32'd1);
    check("fwd_rsp_tag", {27'd0, o_rsp_tag}, 32'd7);
    check("fwd_rsp_err", {31'd0, o_rsp_err}, 32'd0);
    i_rsp_ready = 1'b1;
    tick();
    i_rsp_ready = 1'b0;
    check("fwd_ready_after_hs", {31'd0, o_req_ready}, 32'd1);
    check("fwd_alu_op_held", {27'd0, o_alu_op}, 32'd1);

    // Multiplier: 0x10*0xF1 = 0xF10; all-ones squared wraps to 1
    run_op("mul_a", 5'd13, 32'h10, 32'hF1, 5'd4, 33, 32'h0000_0F10, 1'b0, 1'b0);
    run_op("mul_b", 5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 33,
           32'h0000_0001, 1'b0, 1'b0);

    // Illegal opcodes
    run_op("illegal20", 5'd20, 32'h1234, 32'h5678, 5'd3, 1, 32'd0, 1'b0, 1'b1);
    run_op("illegal31", 5'd31, 32'h1, 32'h2, 5'd30, 1, 32'd0, 1'b0, 1'b1);

    // Backpressure: op 2, x=5, y=3 -> A5A5_0000 + 6 + 2 = A5A5_0008
    accept(5'd2, 32'h5, 32'h3, 5'd11, waited);
    wait_rsp(lat);
    check("bp_latency", lat, 32'd2);
    held_w      = o_rsp_w;
    check("bp_rsp_w", held_w, 32'hA5A5_0008);
    i_req_op    = 5'd3;
    i_req_x     = 32'h7;
    i_req_y     = 32'h1;
    i_req_tag   = 5'd9;
    i_req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid_held", {31'd0, o_rsp_valid}, 32'd1);
      check("bp_w_stable", o_rsp_w, 32'hA5A5_0008);
      check("bp_tag_stable", {27'd0, o_rsp_tag}, 32'd11);
      check("bp_req_ready", {31'd0, o_req_ready}, 32'd0);
      check("bp_not_captured", {27'd0, o_alu_op}, 32'd2);
    end
    i_rsp_ready = 1'b1;
    tick();
    i_rsp_ready = 1'b0;
    check("bp_hs_ready", {31'd0, o_req_ready}, 32'd1);
    check("bp_hs_no_capture", {27'd0, o_alu_op}, 32'd2);
    tick();
    i_req_valid = 1'b0;
    check("bp_new_alu_op", {27'd0, o_alu_op}, 32'd3);
    check("bp_new_busy", {31'd0, o_busy}, 32'd1);
    wait_rsp(lat);
    check("bp_new_latency", lat, 32'd2);
    // A5A5_0000 + (7^1=6) + 3
    check("bp_new_rsp_w", o_rsp_w, 32'hA5A5_0009);
    check("bp_new_rsp_tag", {27'd0, o_rsp_tag}, 32'd9);
    i_rsp_ready = 1'b1;
    tick();
    i_rsp_ready = 1'b0;

    // Reset in the middle of a multiply
    accept(5'd13, 32'h10, 32'hF1, 5'd12, waited);
    for (int i = 0; i < 10; i++) tick();
    check("rstmul_busy_before", {31'd0, o_busy}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstmul_req_ready", {31'd0, o_req_ready}, 32'd1);
    check("rstmul_busy", {31'd0, o_busy}, 32'd0);
    check("rstmul_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
    check("rstmul_alu_op", {27'd0, o_alu_op}, 32'd0);
    check("rstmul_alu_x", o_alu_x, 32'd0);
    check("rstmul_alu_y", o_alu_y, 32'd0);
    check("rstmul_rsp_w", o_rsp_w, 32'd0);
    check("rstmul_rsp_tag", {27'd0, o_rsp_tag}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (o_rsp_valid) saw_valid = 1'b1;
    end
    check("rstmul_no_rsp", {31'd0, saw_valid}, 32'd0);
    run_op("post_rst", 5'd12, 32'h3, 32'h1, 5'd1, 2, 32'hA5A5_000E, 1'b0, 1'b0);

    // Back-to-back sweep of ops 0..12 with rsp_ready held high
    i_rsp_ready = 1'b1;
    for (int op = 0; op <= 12; op++) begin
      logic [4:0]       op5;
      logic [WIDTH-1:0] opw;
      op5 = 5'(op);
      opw = 32'(op);
      run_op($sformatf("sweep%0d", op), op5, 32'h1234 + opw, 32'h1234 + opw,
             op5 + 5'd16, 2, 32'hA5A5_0000 + opw, op5[0], 1'b0);
    end
    i_rsp_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
